imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 81 ++++++++
 rtl/imem_loader_encoder.sv | 70 +++++++
 rtl/imem_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader:
//     - mnem_e    : 5-bit mnemonic code (0..30 legal, 31 reserved)
//     - OP_* / FN_* : MIPS-I primary opcode and R-type function codes
//     - state_e   : loader FSM states
//     - r_word / i_word / j_word : instruction-format packers
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [4:0] {
    M_ADD   = 5'd0,  M_ADDU  = 5'd1,  M_SUB   = 5'd2,  M_AND   = 5'd3,
    M_OR    = 5'd4,  M_XOR   = 5'd5,  M_NOR   = 5'd6,  M_SLT   = 5'd7,
    M_SLTU  = 5'd8,  M_SLL   = 5'd9,  M_SLLV  = 5'd10, M_SRL   = 5'd11,
    M_SRLV  = 5'd12, M_SRA   = 5'd13, M_SRAV  = 5'd14, M_JR    = 5'd15,
    M_JALR  = 5'd16, M_LW    = 5'd17, M_SW    = 5'd18, M_ADDI  = 5'd19,
    M_ADDIU = 5'd20, M_SLTI  = 5'd21, M_SLTIU = 5'd22, M_ORI   = 5'd23,
    M_LUI   = 5'd24, M_ANDI  = 5'd25, M_XORI  = 5'd26, M_BEQ   = 5'd27,
    M_BNE   = 5'd28, M_J     = 5'd29, M_JAL   = 5'd30, M_RSVD  = 5'd31
  } mnem_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/imem_loader_encoder.sv
// -----------------------------------------------------------------------------
// mips_encoder
//   Purely combinational MIPS-I encoder for the 31 supported mnemonics.
//   Ports:
//     mnem   in  5   mnemonic code (mnem_e)
//     rs/rt/rd/shamt in 5 each  register / shift fields
//     imm    in  26  imm16 in [15:0] or jump target in [25:0]
//     word   out 32  encoded instruction
//     illegal out 1  reserved mnemonic (31); word is 0 in that case
//   Fields that a format does not use are forced to 0 so the stored image
//   is canonical regardless of what the producer left in unused fields.
// -----------------------------------------------------------------------------
module mips_encoder
  import imem_loader_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      // Three-register ALU ops: shamt forced 0
      M_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      M_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      M_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      M_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      M_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      M_XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      M_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      M_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      M_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      M_SLLV:  word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      M_SRLV:  word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      M_SRAV:  word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      // Immediate shifts: rs forced 0, shamt kept
      M_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      M_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      M_SRA:   word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      // Register jumps
      M_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      M_JALR:  word = r_word(rs, 5'd0, rd, 5'd0, FN_JALR);
      // I-type: only imm[15:0] is used
      M_LW:    word = i_word(OP_LW,    rs, rt, imm[15:0]);
      M_SW:    word = i_word(OP_SW,    rs, rt, imm[15:0]);
      M_ADDI:  word = i_word(OP_ADDI,  rs, rt, imm[15:0]);
      M_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
      M_SLTI:  word = i_word(OP_SLTI,  rs, rt, imm[15:0]);
      M_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm[15:0]);
      M_ORI:   word = i_word(OP_ORI,   rs, rt, imm[15:0]);
      M_ANDI:  word = i_word(OP_ANDI,  rs, rt, imm[15:0]);
      M_XORI:  word = i_word(OP_XORI,  rs, rt, imm[15:0]);
      M_BEQ:   word = i_word(OP_BEQ,   rs, rt, imm[15:0]);
      M_BNE:   word = i_word(OP_BNE,   rs, rt, imm[15:0]);
      M_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
      // J-type
      M_J:     word = j_word(OP_J,   imm);
      M_JAL:   word = j_word(OP_JAL, imm);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Accepts a stream of instruction descriptors, encodes each into a MIPS-I
//   word and writes it to instruction memory one cycle later at an
//   incrementing address, then enables the CPU once the program is loaded.
//   Ports:
//     clk, rst_n          clock / async active-low reset
//     start               pulse: begin a load session (ignored in LOAD/DRAIN)
//     in_valid/in_ready   descriptor handshake (ready only in LOAD)
//     in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last  descriptor
//     imem_we/addr/wd     registered instruction-memory write port
//     cpu_enable          high only in RUN
//     err                 sticky error (reserved mnemonic or memory full)
//     checksum            XOR of all written words
//   Build option: IMEM_LOADER_CHECKSUM_EN enables the checksum register;
//   otherwise checksum is tied to 0.
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 1024,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_mnem,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [25:0]   in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic          cpu_enable,
  output logic          err,
  output logic [31:0]   checksum
);

  state_e        state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic          err_q, err_d;
  logic          clr;

  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          xfer;
  logic          full;

  mips_encoder u_enc (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign in_ready = (state_q == ST_LOAD);
  assign xfer     = in_valid && in_ready;
  // IMEM_WORDS is a power of two, so pointer == IMEM_WORDS is exactly the MSB.
  assign full     = ptr_q[AW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          err_d   = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (enc_illegal || full) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q[AW-1:0];
            wd_d    = enc_word;
            ptr_d   = ptr_q + {{AW{1'b0}}, 1'b1};
            if (in_last) state_d = ST_DRAIN;
          end
        end
      end
      // The final write is on the bus during DRAIN; RUN follows so the CPU
      // never sees the enable concurrently with a write strobe.
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  // A session-clearing start never coincides with a live write strobe
  // (writes only occur in LOAD/DRAIN), so clear simply takes priority.
  always_comb begin
    cks_d = cks_q;
    if (clr)       cks_d = '0;
    else if (we_q) cks_d = cks_q ^ wd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cks_q <= '0;
    else        cks_q <= cks_d;
  end

  assign checksum = cks_q;
`else
  assign checksum = 32'd0;
`endif

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wd    = wd_q;
  assign cpu_enable = (state_q == ST_RUN);
  assign err        = err_q;

endmodule
